// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared size encodings, load FSM states and access helpers for the MEM stage
package mips_mem_pkg;

  // Access size encoding shared by MemWriteM and MemReadM
  localparam logic [1:0] SZ_NONE = 2'b00;
  localparam logic [1:0] SZ_BYTE = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;
  localparam logic [1:0] SZ_WORD = 2'b11;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } ld_state_e;

  // Half accesses need an even address, word accesses a multiple of four
  function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] lane);
    return ((sz == SZ_HALF) && lane[0]) || ((sz == SZ_WORD) && (lane != 2'b00));
  endfunction

  // Pick the addressed lane(s) out of a little-endian word and widen to 32 bits
  function automatic logic [31:0] extend_load(input logic [31:0] word, input logic [1:0] sz,
                                              input logic [1:0] lane, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[8*lane +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (sz)
      SZ_BYTE: return {{24{b[7] & ~uns}}, b};
      SZ_HALF: return {{16{h[15] & ~uns}}, h};
      default: return word;
    endcase
  endfunction

endpackage

// File: rtl/mem_wb_stage_pipe_if.sv
// rtl/mem_wb_stage_pipe_if.sv - M-stage inputs and W-stage outputs of the memory stage
interface mem_wb_stage_pipe_if #(
  parameter int DATA_W = 32
);
  // Driven by the M stage / hazard unit
  logic              RegWriteM;
  logic              jumpM;
  logic [1:0]        MemWriteM;
  logic [1:0]        MemReadM;
  logic              LoadUnsM;
  logic [4:0]        WriteRegM;
  logic [DATA_W-1:0] ALUOutM;
  logic [DATA_W-1:0] WriteDataM;
  logic [DATA_W-1:0] PCPlus4M;
  logic              FlushW;

  // Produced by the memory stage
  logic              MemBusyM;
  logic              MisalignM;
  logic              RegWriteW;
  logic              jumpW;
  logic [1:0]        MemReadW;
  logic              MisalignW;
  logic [4:0]        WriteRegW;
  logic [DATA_W-1:0] ALUOutW;
  logic [DATA_W-1:0] ReadDataW;
  logic [DATA_W-1:0] PCPlus8W;

  modport master (
    output RegWriteM, jumpM, MemWriteM, MemReadM, LoadUnsM, WriteRegM,
           ALUOutM, WriteDataM, PCPlus4M, FlushW,
    input  MemBusyM, MisalignM, RegWriteW, jumpW, MemReadW, MisalignW,
           WriteRegW, ALUOutW, ReadDataW, PCPlus8W
  );

  modport slave (
    input  RegWriteM, jumpM, MemWriteM, MemReadM, LoadUnsM, WriteRegM,
           ALUOutM, WriteDataM, PCPlus4M, FlushW,
    output MemBusyM, MisalignM, RegWriteW, jumpW, MemReadW, MisalignW,
           WriteRegW, ALUOutW, ReadDataW, PCPlus8W
  );

endinterface

// File: rtl/dmem_bytewise.sv
// rtl/dmem_bytewise.sv - byte-strobed data RAM with an RD_LAT-deep read pipeline
module dmem_bytewise #(
  parameter int MEM_WORDS = 256,
  parameter int RD_LAT    = 1
) (
  input  logic                         clk,
  input  logic [3:0]                   we,
  input  logic [$clog2(MEM_WORDS)-1:0] addr,
  input  logic [31:0]                  wdata,
  output logic [31:0]                  rdata
);

  logic [31:0] mem  [MEM_WORDS];
  logic [31:0] pipe [RD_LAT];

  // Commit only the strobed byte lanes; other lanes keep their contents
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we[b]) begin
        mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Read every cycle; the address is held during a load, so stage RD_LAT-1 carries that word
  always_ff @(posedge clk) begin
    pipe[0] <= mem[addr];
    for (int i = 1; i < RD_LAT; i++) begin
      pipe[i] <= pipe[i-1];
    end
  end

  assign rdata = pipe[RD_LAT-1];

endmodule

// File: rtl/mem_wb_stage_pipe.sv
// rtl/mem_wb_stage_pipe.sv - MIPS memory stage with multi-cycle load FSM and MEM/WB register
module mem_wb_stage_pipe
  import mips_mem_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int MEM_WORDS = 256,
  parameter int RD_LAT    = 1
) (
  input  logic                clk,
  input  logic                reset,
  mem_wb_stage_pipe_if.slave  bus
);

  localparam int         AW       = $clog2(MEM_WORDS);
  localparam logic [0:0] S_IDLE   = IDLE;
  localparam logic [0:0] S_WAIT   = WAIT;
  localparam logic [2:0] CNT_INIT = 3'(RD_LAT - 1);

  logic [0:0]        state;
  logic [2:0]        cnt;
  logic [1:0]        lane;
  logic [AW-1:0]     widx;
  logic              store_op;
  logic              mis_m;
  logic              load_req;
  logic              busy;
  logic [3:0]        strb;
  logic [31:0]       wdata;
  logic [DATA_W-1:0] rd_raw;
  logic [1:0]        w_lane;
  logic              w_uns;

  assign lane     = bus.ALUOutM[1:0];
  assign widx     = bus.ALUOutM[AW+1:2];
  assign store_op = (bus.MemWriteM != SZ_NONE);
  // A store wins over a simultaneous load, so only the store's size is checked then
  assign mis_m    = store_op ? is_misaligned(bus.MemWriteM, lane)
                             : is_misaligned(bus.MemReadM, lane);
  assign load_req = !store_op && (bus.MemReadM != SZ_NONE) && !mis_m;

  assign bus.MisalignM = mis_m;
  assign bus.MemBusyM  = busy;

  // Stall every cycle of a load except the last; nothing stalls while reset is held
  always_comb begin
    busy = 1'b0;
    if (!reset && (RD_LAT > 1)) begin
      if (state == S_IDLE) begin
        busy = load_req;
      end else begin
        busy = (cnt != 3'd1);
      end
    end
  end

  // Build lane strobes and replicate store data so each lane sees its own bytes
  always_comb begin
    strb  = 4'b0000;
    wdata = bus.WriteDataM;
    if (!mis_m) begin
      case (bus.MemWriteM)
        SZ_BYTE: begin
          strb  = 4'b0001 << lane;
          wdata = {4{bus.WriteDataM[7:0]}};
        end
        SZ_HALF: begin
          strb  = lane[1] ? 4'b1100 : 4'b0011;
          wdata = {2{bus.WriteDataM[15:0]}};
        end
        SZ_WORD: strb = 4'b1111;
        default: strb = 4'b0000;
      endcase
    end
  end

  dmem_bytewise #(
    .MEM_WORDS (MEM_WORDS),
    .RD_LAT    (RD_LAT)
  ) u_dmem (
    .clk   (clk),
    .we    (strb),
    .addr  (widx),
    .wdata (wdata),
    .rdata (rd_raw)
  );

  // Load FSM: count down the remaining latency; flushes never abort a pending load
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= 3'd0;
    end else if (RD_LAT > 1) begin
      case (state)
        S_IDLE: begin
          if (load_req) begin
            state <= S_WAIT;
            cnt   <= CNT_INIT;
          end
        end
        default: begin
          if (cnt == 3'd1) begin
            state <= S_IDLE;
            cnt   <= 3'd0;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
      endcase
    end
  end

  // MEM/WB register: reset, then flush, then stall bubble, otherwise capture M
  always_ff @(posedge clk) begin
    if (reset || bus.FlushW) begin
      bus.RegWriteW <= 1'b0;
      bus.jumpW     <= 1'b0;
      bus.MemReadW  <= SZ_NONE;
      bus.MisalignW <= 1'b0;
      bus.WriteRegW <= 5'd0;
      bus.ALUOutW   <= '0;
      bus.PCPlus8W  <= '0;
      w_lane        <= 2'b00;
      w_uns         <= 1'b0;
    end else begin
      bus.RegWriteW <= bus.RegWriteM && !mis_m && !busy;
      bus.MemReadW  <= (load_req && !busy) ? bus.MemReadM : SZ_NONE;
      bus.jumpW     <= bus.jumpM;
      bus.MisalignW <= mis_m;
      bus.WriteRegW <= bus.WriteRegM;
      bus.ALUOutW   <= bus.ALUOutM;
      bus.PCPlus8W  <= bus.PCPlus4M + DATA_W'(4);
      w_lane        <= lane;
      w_uns         <= bus.LoadUnsM;
    end
  end

  // The RAM's last read stage lines up with the W register; only real loads expose data
  assign bus.ReadDataW = (bus.MemReadW != SZ_NONE)
                       ? extend_load(rd_raw, bus.MemReadW, w_lane, w_uns) : '0;

endmodule

// File: tb/tb_mem_wb_stage_pipe.sv
// tb/tb_mem_wb_stage_pipe.sv - self-checking bench for mem_wb_stage_pipe at RD_LAT 1 and 3
module tb_mem_wb_stage_pipe;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_wb_stage_pipe_if #(.DATA_W(32)) b1 ();
  mem_wb_stage_pipe_if #(.DATA_W(32)) b3 ();

  mem_wb_stage_pipe #(.DATA_W(32), .MEM_WORDS(256), .RD_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .bus(b1));
  mem_wb_stage_pipe #(.DATA_W(32), .MEM_WORDS(256), .RD_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .bus(b3));

  int total = 0;
  int bad   = 0;

  // Byte-addressed image of each DUT's memory (index 0: RD_LAT=1, 1: RD_LAT=3)
  logic [7:0] mm [2][1024];

  logic        o_busy, o_misM, o_rw, o_jmp, o_mis;
  logic [1:0]  o_mr;
  logic [4:0]  o_wr;
  logic [31:0] o_alu, o_rd, o_pc8;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic misal(input logic [1:0] sz, input logic [31:0] a);
    return ((sz == 2'd2) && (a % 2 != 0)) || ((sz == 2'd3) && (a % 4 != 0));
  endfunction

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd1) ? 1 : (sz == 2'd2) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_load(input int d, input logic [31:0] a,
                                             input logic [1:0] sz, input logic uns);
    int base, n;
    logic [31:0] v;
    base = int'(a % 1024);
    n = nbytes(sz);
    v = 32'h0;
    for (int i = 0; i < n; i++) v = v | (32'(mm[d][base + i]) << (8 * i));
    if (!uns && (n < 4) && v[8*n-1]) v = v | ~((32'h1 << (8 * n)) - 32'h1);
    return v;
  endfunction

  task automatic model_store(input int d, input logic [31:0] a, input logic [1:0] sz,
                             input logic [31:0] wd);
    int base;
    base = int'(a % 1024);
    for (int i = 0; i < nbytes(sz); i++) mm[d][base + i] = 8'(wd >> (8 * i));
  endtask

  task automatic drive(input int d, input logic [1:0] we, input logic [1:0] re,
                       input logic uns, input logic rw, input logic jmp,
                       input logic [4:0] wr, input logic [31:0] alu,
                       input logic [31:0] wd, input logic [31:0] pc4);
    if (d == 0) begin
      b1.MemWriteM = we; b1.MemReadM = re; b1.LoadUnsM = uns; b1.RegWriteM = rw;
      b1.jumpM = jmp; b1.WriteRegM = wr; b1.ALUOutM = alu; b1.WriteDataM = wd;
      b1.PCPlus4M = pc4;
    end else begin
      b3.MemWriteM = we; b3.MemReadM = re; b3.LoadUnsM = uns; b3.RegWriteM = rw;
      b3.jumpM = jmp; b3.WriteRegM = wr; b3.ALUOutM = alu; b3.WriteDataM = wd;
      b3.PCPlus4M = pc4;
    end
  endtask

  task automatic set_flush(input int d, input logic fl);
    if (d == 0) b1.FlushW = fl;
    else        b3.FlushW = fl;
  endtask

  task automatic sample(input int d);
    if (d == 0) begin
      o_busy = b1.MemBusyM; o_misM = b1.MisalignM; o_rw = b1.RegWriteW; o_jmp = b1.jumpW;
      o_mis = b1.MisalignW; o_mr = b1.MemReadW; o_wr = b1.WriteRegW; o_alu = b1.ALUOutW;
      o_rd = b1.ReadDataW; o_pc8 = b1.PCPlus8W;
    end else begin
      o_busy = b3.MemBusyM; o_misM = b3.MisalignM; o_rw = b3.RegWriteW; o_jmp = b3.jumpW;
      o_mis = b3.MisalignW; o_mr = b3.MemReadW; o_wr = b3.WriteRegW; o_alu = b3.ALUOutW;
      o_rd = b3.ReadDataW; o_pc8 = b3.PCPlus8W;
    end
  endtask

  task automatic chk_zero(input string pre);
    chk({pre, " RegWriteW"}, 32'(o_rw), 32'h0);
    chk({pre, " jumpW"},     32'(o_jmp), 32'h0);
    chk({pre, " MemReadW"},  32'(o_mr), 32'h0);
    chk({pre, " MisalignW"}, 32'(o_mis), 32'h0);
    chk({pre, " WriteRegW"}, 32'(o_wr), 32'h0);
    chk({pre, " ALUOutW"},   o_alu, 32'h0);
    chk({pre, " ReadDataW"}, o_rd, 32'h0);
    chk({pre, " PCPlus8W"},  o_pc8, 32'h0);
  endtask

  // One instruction through M: one cycle, or RD_LAT cycles for an aligned load
  task automatic op(input int d, input logic [1:0] we, input logic [1:0] re,
                    input logic uns, input logic rw, input logic jmp, input logic [4:0] wr,
                    input logic [31:0] alu, input logic [31:0] wd, input logic [31:0] pc4,
                    input int flush_at);
    int lat, cycles;
    logic store, mis, is_load;
    logic [1:0] sz;
    logic [31:0] exp_rd;
    string pre;
    lat     = (d == 0) ? 1 : 3;
    store   = (we != 2'b00);
    sz      = store ? we : re;
    mis     = misal(sz, alu);
    is_load = !store && (re != 2'b00) && !mis;
    exp_rd  = is_load ? model_load(d, alu, re, uns) : 32'h0;
    cycles  = is_load ? lat : 1;
    drive(d, we, re, uns, rw, jmp, wr, alu, wd, pc4);
    for (int k = 0; k < cycles; k++) begin
      pre = $sformatf("d%0d a=%h k%0d", d, alu, k);
      set_flush(d, flush_at == k);
      #1;
      sample(d);
      chk({pre, " MemBusyM"},  32'(o_busy), 32'(is_load && (k < cycles - 1)));
      chk({pre, " MisalignM"}, 32'(o_misM), 32'(mis));
      @(posedge clk);
      #1;
      sample(d);
      if (flush_at == k) begin
        chk_zero({pre, " flush"});
      end else if (k < cycles - 1) begin
        chk({pre, " bubble RegWriteW"}, 32'(o_rw), 32'h0);
        chk({pre, " bubble MemReadW"},  32'(o_mr), 32'h0);
      end else begin
        chk({pre, " RegWriteW"}, 32'(o_rw), 32'(rw && !mis));
        chk({pre, " jumpW"},     32'(o_jmp), 32'(jmp));
        chk({pre, " MemReadW"},  32'(o_mr), 32'(is_load ? re : 2'b00));
        chk({pre, " MisalignW"}, 32'(o_mis), 32'(mis));
        chk({pre, " WriteRegW"}, 32'(o_wr), 32'(wr));
        chk({pre, " ALUOutW"},   o_alu, alu);
        chk({pre, " ReadDataW"}, o_rd, exp_rd);
        chk({pre, " PCPlus8W"},  o_pc8, pc4 + 32'd4);
      end
    end
    if (store && !mis) model_store(d, alu, we, wd);
    set_flush(d, 1'b0);
  endtask

  initial begin
    int kind, fa;
    logic [1:0] sz, we, re;
    logic [31:0] a;

    for (int d = 0; d < 2; d++) begin
      drive(d, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
      set_flush(d, 1'b0);
      for (int i = 0; i < 1024; i++) mm[d][i] = 8'h00;
    end
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      sample(d);
      chk_zero($sformatf("reset d%0d", d));
      chk($sformatf("reset d%0d MemBusyM", d), 32'(o_busy), 32'h0);
    end
    reset = 1'b0;

    // RD_LAT=1 directed
    op(0, 2'd3, 2'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h10, 32'hDEADBEEF, 32'h100, -1);
    op(0, 2'd0, 2'd1, 1'b1, 1'b1, 1'b0, 5'd3, 32'h11, 32'h0, 32'h104, -1);
    chk("lbu 0x11", o_rd, 32'h000000BE);
    op(0, 2'd0, 2'd1, 1'b0, 1'b1, 1'b0, 5'd4, 32'h13, 32'h0, 32'h108, -1);
    chk("lb 0x13", o_rd, 32'hFFFFFFDE);
    op(0, 2'd3, 2'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h20, 32'h11112222, 32'h10C, -1);
    op(0, 2'd2, 2'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h22, 32'hABCD8001, 32'h110, -1);
    op(0, 2'd0, 2'd3, 1'b0, 1'b1, 1'b0, 5'd5, 32'h20, 32'h0, 32'h114, -1);
    chk("lw 0x20", o_rd, 32'h80012222);
    op(0, 2'd0, 2'd2, 1'b0, 1'b1, 1'b0, 5'd6, 32'h22, 32'h0, 32'h118, -1);
    chk("lh 0x22", o_rd, 32'hFFFF8001);
    op(0, 2'd3, 2'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h04, 32'h01234567, 32'h11C, -1);
    op(0, 2'd3, 2'd0, 1'b0, 1'b1, 1'b0, 5'd7, 32'h06, 32'hFFFFFFFF, 32'h120, -1);
    chk("sw 0x06 MisalignW", 32'(o_mis), 32'h1);
    op(0, 2'd0, 2'd3, 1'b0, 1'b1, 1'b0, 5'd8, 32'h04, 32'h0, 32'h124, -1);
    chk("lw 0x04 unchanged", o_rd, 32'h01234567);
    op(0, 2'd0, 2'd2, 1'b0, 1'b1, 1'b0, 5'd9, 32'h05, 32'h0, 32'h128, -1);
    chk("lh 0x05 MisalignW", 32'(o_mis), 32'h1);
    chk("lh 0x05 RegWriteW", 32'(o_rw), 32'h0);
    op(0, 2'd3, 2'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h400, 32'h5A5AA5A5, 32'h12C, -1);
    op(0, 2'd0, 2'd3, 1'b0, 1'b1, 1'b0, 5'd10, 32'h000, 32'h0, 32'h130, -1);
    chk("alias 0x400->0x000", o_rd, 32'h5A5AA5A5);
    op(0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b1, 5'd31, 32'h1234, 32'h0, 32'hFFFFFFFC, -1);
    chk("PCPlus8W wrap", o_pc8, 32'h00000000);
    op(0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b1, 5'd11, 32'h55, 32'h0, 32'h140, 0);
    chk("flush RegWriteW", 32'(o_rw), 32'h0);
    op(0, 2'd1, 2'd3, 1'b0, 1'b1, 1'b0, 5'd12, 32'h30, 32'h000000AA, 32'h144, -1);

    // RD_LAT=3 directed
    op(1, 2'd3, 2'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h10, 32'hCAFEF00D, 32'h200, -1);
    op(1, 2'd0, 2'd3, 1'b0, 1'b1, 1'b0, 5'd7, 32'h10, 32'h0, 32'h204, -1);
    chk("lat3 lw data", o_rd, 32'hCAFEF00D);
    chk("lat3 lw RegWriteW", 32'(o_rw), 32'h1);
    op(1, 2'd0, 2'd3, 1'b0, 1'b1, 1'b0, 5'd8, 32'h10, 32'h0, 32'h208, 1);
    chk("lat3 flush-in-wait data", o_rd, 32'hCAFEF00D);
    op(1, 2'd0, 2'd1, 1'b1, 1'b1, 1'b0, 5'd9, 32'h12, 32'h0, 32'h20C, -1);
    chk("lat3 lbu 0x12", o_rd, 32'h000000FE);

    // Reset while the FSM is in WAIT
    drive(1, 2'd0, 2'd3, 1'b0, 1'b1, 1'b0, 5'd2, 32'h10, 32'h0, 32'h210);
    #1;
    sample(1);
    chk("rst-wait busy before", 32'(o_busy), 32'h1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
    #1;
    sample(1);
    chk("rst-wait busy after", 32'(o_busy), 32'h0);
    chk_zero("rst-wait W");
    op(1, 2'd0, 2'd3, 1'b0, 1'b1, 1'b0, 5'd3, 32'h10, 32'h0, 32'h214, -1);
    chk("lat3 lw after reset", o_rd, 32'hCAFEF00D);

    // Randomized traffic on words 0..15 with alias bits above the array
    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < 16; w++) begin
        op(d, 2'd3, 2'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'(w * 4), $urandom, $urandom, -1);
      end
      for (int it = 0; it < 80; it++) begin
        kind = $urandom_range(0, 2);
        sz   = 2'($urandom_range(1, 3));
        a    = 32'($urandom_range(0, 63)) | (32'($urandom_range(0, 15)) << 10);
        we   = 2'b00;
        re   = 2'b00;
        if (kind == 0) begin
          we = sz;
          if ($urandom_range(0, 3) == 0) re = 2'($urandom_range(1, 3));
        end else if (kind == 1) begin
          re = sz;
        end
        fa = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 2) : -1;
        op(d, we, re, 1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom), a,
           $urandom, $urandom, fa);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
